// File: rtl/mcpu.sv
// mcpu - multi-cycle CPU core with request/acknowledge instruction and data ports.
//
// Each instruction runs FETCH -> EXEC (-> MEM for loads/stores) -> FETCH. HALT
// instructions and bus timeouts park the core in HALTED until reset.
//
// Instruction word: [31:26] opcode, [25:21] rd, [20:16] rs1, [15:11] rs2,
// [15:0] imm16 (sign-extended), [25:0] jump target (zero-extended).
//   00 ADD  01 SUB  02 AND  03 OR  04 XOR   rd = rs1 op rs2
//   08 ADDI                                 rd = rs1 + imm16
//   10 LW   11 LH   12 LB                   rd = mem[rs1 + imm16]
//   14 SW   15 SH   16 SB                   mem[rs1 + imm16] = reg[rd]
//   20 JMP  3E DUMP  3F HALT; any other opcode is a no-op.
// Register r0 always reads as zero. Registers are not cleared by reset.
//
// Parameters: ADDR_W (16..32), RESET_PC, MEM_TIMEOUT (0 disables the timeout).
// Ports:
//   clk, reset (synchronous, active-low)
//   imemReq/imemAddr/imemAck/imemData               instruction fetch
//   dmemReq/dmemWe/dmemMode/dmemAddr/dmemWData/
//   dmemAck/dmemRData                               data access
//   haltTriggered, fault (sticky), debugDump (one-cycle pulse)
// Optional: define MCPU_PERF_COUNTERS_EN to add cycleCount and instret outputs.

package mcpu_pkg;
  typedef enum logic [1:0] {
    MEM_WORD = 2'd0,
    MEM_HALF = 2'd1,
    MEM_BYTE = 2'd2
  } mem_mode;
endpackage

module mcpu
  import mcpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic              imemAck,
  input  logic [31:0]       imemData,
  output logic              dmemReq,
  output logic              dmemWe,
  output mem_mode           dmemMode,
  output logic [ADDR_W-1:0] dmemAddr,
  output logic [31:0]       dmemWData,
  input  logic              dmemAck,
  input  logic [31:0]       dmemRData,
  output logic              haltTriggered,
  output logic              fault,
  output logic              debugDump
`ifdef MCPU_PERF_COUNTERS_EN
  ,
  output logic [31:0]       cycleCount,
  output logic [31:0]       instret
`endif
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);
  localparam logic [WAIT_W:0]   TIMEOUT_V  = (WAIT_W + 1)'(MEM_TIMEOUT);

  localparam logic [5:0] OP_ADD  = 6'h00, OP_SUB  = 6'h01, OP_AND = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03, OP_XOR  = 6'h04, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h10, OP_LH   = 6'h11, OP_LB  = 6'h12;
  localparam logic [5:0] OP_SW   = 6'h14, OP_SH   = 6'h15, OP_SB  = 6'h16;
  localparam logic [5:0] OP_JMP  = 6'h20, OP_DUMP = 6'h3E, OP_HALT = 6'h3F;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALTED} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ireg_q, ireg_d;
  logic [31:0]       rf_q [32];
  logic [31:0]       rf_d [32];
  logic              halt_q, halt_d, fault_q, fault_d, dump_q, dump_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  mem_mode           dmem_mode_q, dmem_mode_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]       dmem_wdata_q, dmem_wdata_d;
  logic [31:0]       cycle_q, cycle_d, instret_q, instret_d;

  // Decoded fields and datapath
  logic [5:0]        opcode;
  logic [4:0]        rd_idx, rs1_idx, rs2_idx;
  logic [31:0]       imm_ext, r1, r2, alu_result;
  logic              is_store, ls_en, alu_we, jmp_en, x_halt, x_debug_dump;
  mem_mode           ls_mode;
  logic [ADDR_W-1:0] pc_next;
  logic [WAIT_W:0]   wait_inc;
  logic              timeout_hit, running;

  assign opcode  = ireg_q[31:26];
  assign rd_idx  = ireg_q[25:21];
  assign rs1_idx = ireg_q[20:16];
  assign rs2_idx = ireg_q[15:11];
  assign imm_ext = {{16{ireg_q[15]}}, ireg_q[15:0]};

  // Stores take their data register from the rd field so imm16 stays intact.
  assign is_store = (opcode == OP_SW) || (opcode == OP_SH) || (opcode == OP_SB);
  assign r1 = rf_q[rs1_idx];
  assign r2 = rf_q[is_store ? rd_idx : rs2_idx];

  always_comb begin
    ls_en        = 1'b0;
    alu_we       = 1'b0;
    jmp_en       = 1'b0;
    x_halt       = 1'b0;
    x_debug_dump = 1'b0;
    ls_mode      = MEM_WORD;
    alu_result   = r1 + imm_ext;
    case (opcode)
      OP_ADD:  begin alu_result = r1 + r2; alu_we = 1'b1; end
      OP_SUB:  begin alu_result = r1 - r2; alu_we = 1'b1; end
      OP_AND:  begin alu_result = r1 & r2; alu_we = 1'b1; end
      OP_OR:   begin alu_result = r1 | r2; alu_we = 1'b1; end
      OP_XOR:  begin alu_result = r1 ^ r2; alu_we = 1'b1; end
      OP_ADDI: alu_we = 1'b1;
      OP_LW, OP_SW: ls_en = 1'b1;
      OP_LH, OP_SH: begin ls_en = 1'b1; ls_mode = MEM_HALF; end
      OP_LB, OP_SB: begin ls_en = 1'b1; ls_mode = MEM_BYTE; end
      OP_JMP:  jmp_en = 1'b1;
      OP_DUMP: x_debug_dump = 1'b1;
      OP_HALT: x_halt = 1'b1;
      default: ;
    endcase
  end

  assign pc_next  = jmp_en ? ADDR_W'(ireg_q[25:0]) : pc_q + ADDR_W'(1);
  assign wait_inc = {1'b0, wait_q} + (WAIT_W + 1)'(1);
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_inc == TIMEOUT_V);
  // FETCH is idle for the single cycle after reset release, before its request is raised.
  assign running = (state_q != S_HALTED) && ((state_q != S_FETCH) || imem_req_q);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ireg_d       = ireg_q;
    rf_d         = rf_q;
    halt_d       = halt_q;
    fault_d      = fault_q;
    dump_d       = 1'b0;
    wait_d       = wait_q;
    dmem_we_d    = dmem_we_q;
    dmem_mode_d  = dmem_mode_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    instret_d    = instret_q;
    cycle_d      = running ? cycle_q + 32'd1 : cycle_q;
    case (state_q)
      S_FETCH: if (imem_req_q) begin
        if (imemAck) begin
          ireg_d  = imemData;
          state_d = S_EXEC;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          halt_d  = 1'b1;
          state_d = S_HALTED;
        end else begin
          wait_d = wait_inc[WAIT_W-1:0];
        end
      end
      S_EXEC: begin
        wait_d = '0;
        if (x_halt) begin
          halt_d  = 1'b1;
          state_d = S_HALTED;
        end else if (ls_en) begin
          dmem_addr_d  = ADDR_W'(alu_result);
          dmem_wdata_d = r2;
          dmem_we_d    = is_store;
          dmem_mode_d  = ls_mode;
          state_d      = S_MEM;
        end else begin
          if (alu_we) rf_d[rd_idx] = alu_result;
          dump_d    = x_debug_dump;
          pc_d      = pc_next;
          instret_d = instret_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      S_MEM: begin
        if (dmemAck) begin
          if (!dmem_we_q) rf_d[rd_idx] = dmemRData;
          pc_d      = pc_next;
          wait_d    = '0;
          instret_d = instret_q + 32'd1;
          state_d   = S_FETCH;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          halt_d  = 1'b1;
          state_d = S_HALTED;
        end else begin
          wait_d = wait_inc[WAIT_W-1:0];
        end
      end
      default: ;
    endcase
    rf_d[0] = '0;
    // Requests are registered from the next state, so acks never reach them combinationally.
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC_V;
      ireg_q       <= '0;
      halt_q       <= 1'b0;
      fault_q      <= 1'b0;
      dump_q       <= 1'b0;
      wait_q       <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_mode_q  <= MEM_WORD;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      cycle_q      <= '0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ireg_q       <= ireg_d;
      rf_q         <= rf_d;
      halt_q       <= halt_d;
      fault_q      <= fault_d;
      dump_q       <= dump_d;
      wait_q       <= wait_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_mode_q  <= dmem_mode_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      cycle_q      <= cycle_d;
      instret_q    <= instret_d;
    end
  end

  assign imemReq       = imem_req_q;
  assign imemAddr      = pc_q;
  assign dmemReq       = dmem_req_q;
  assign dmemWe        = dmem_we_q;
  assign dmemMode      = dmem_mode_q;
  assign dmemAddr      = dmem_addr_q;
  assign dmemWData     = dmem_wdata_q;
  assign haltTriggered = halt_q;
  assign fault         = fault_q;
  assign debugDump     = dump_q;

`ifdef MCPU_PERF_COUNTERS_EN
  assign cycleCount = cycle_q;
  assign instret    = instret_q;
`else
  // Counters are still modelled so the datapath is identical; they are simply not exported.
  logic unused_perf;
  assign unused_perf = ^{cycle_q, instret_q};
`endif

endmodule
